// File: rtl/lsu_store_if.sv
// lsu_store_if: store request handshake and RAMHelper write-port bundle.
interface lsu_store_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [63:0] i_req_addr;
    logic [63:0] i_req_data;
    logic [1:0]  i_req_size;
    logic        o_wen;
    logic [63:0] o_widx;
    logic [63:0] o_wdata;
    logic [63:0] o_wmask;
    logic        o_done;
    modport master (
        output i_req_valid, i_req_addr, i_req_data, i_req_size,
        input  o_req_ready, o_wen, o_widx, o_wdata, o_wmask, o_done
    );
    modport slave (
        input  i_req_valid, i_req_addr, i_req_data, i_req_size,
        output o_req_ready, o_wen, o_widx, o_wdata, o_wmask, o_done
    );
endinterface

// File: rtl/lsu_store.sv
// lsu_store: turns one store request into one or two lane-aligned 64-bit RAMHelper write beats.
module lsu_store #(
    parameter logic [63:0] MEM_BASE = 64'h8000_0000
) (
    input logic        i_clk,
    input logic        i_rst_n,
    lsu_store_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
    state_t      r_state;
    logic        r_wen, r_done, r_split;
    logic [63:0] r_widx, r_wdata, r_wmask, r_d;
    logic [7:0]  r_bm;
    logic [2:0]  r_off;
    logic [2:0]  w_off;
    logic [3:0]  w_nb;
    logic [7:0]  w_bm;
    logic [63:0] w_d, w_base;
    logic        w_split, w_acc;

    function automatic logic [63:0] f_lanes(input logic [7:0] m);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = {8{m[k]}};
        return v;
    endfunction

    assign w_off   = bus.i_req_addr[2:0];
    assign w_nb    = 4'd1 << bus.i_req_size;
    assign w_bm    = 8'((9'd1 << w_nb) - 9'd1);
    assign w_d     = bus.i_req_data & f_lanes(w_bm);
    assign w_base  = (bus.i_req_addr - MEM_BASE) >> 3;
    assign w_split = ({1'b0, w_off} + w_nb) > 4'd8;
    assign w_acc   = bus.i_req_valid && bus.o_req_ready;

    assign bus.o_req_ready = (r_state == IDLE) && i_rst_n;
    assign bus.o_wen       = r_wen;
    assign bus.o_widx      = r_widx;
    assign bus.o_wdata     = r_wdata;
    assign bus.o_wmask     = r_wmask;
    assign bus.o_done      = r_done;

    // Beat outputs are computed one edge early so every write-port signal is a flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_wen   <= 1'b0;
            r_done  <= 1'b0;
            r_widx  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_d     <= '0;
            r_bm    <= '0;
            r_off   <= '0;
            r_split <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_acc) begin
                    r_state <= BEAT0;
                    r_wen   <= 1'b1;
                    r_done  <= !w_split;
                    r_widx  <= w_base;
                    r_wdata <= w_d << {w_off, 3'b000};
                    r_wmask <= f_lanes(8'(w_bm << w_off));
                    r_d     <= w_d;
                    r_bm    <= w_bm;
                    r_off   <= w_off;
                    r_split <= w_split;
                end
                BEAT0: if (r_split) begin
                    r_state <= BEAT1;
                    r_done  <= 1'b1;
                    r_widx  <= r_widx + 64'd1;
                    r_wdata <= r_d >> (7'd64 - {1'b0, r_off, 3'b000});
                    r_wmask <= f_lanes(r_bm >> (4'd8 - {1'b0, r_off}));
                end else begin
                    r_state <= IDLE;
                    r_wen   <= 1'b0;
                    r_done  <= 1'b0;
                    r_widx  <= '0;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_wen   <= 1'b0;
                    r_done  <= 1'b0;
                    r_widx  <= '0;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_store.sv
// tb_lsu_store: directed vectors with hand-computed beats for lsu_store.
module tb_lsu_store;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    lsu_store_if bus();
    lsu_store #(.MEM_BASE(64'h8000_0000)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".wen"}, 64'(bus.o_wen), 64'd0);
        chk({tag, ".widx"}, bus.o_widx, 64'd0);
        chk({tag, ".wdata"}, bus.o_wdata, 64'd0);
        chk({tag, ".wmask"}, bus.o_wmask, 64'd0);
        chk({tag, ".done"}, 64'(bus.o_done), 64'd0);
    endtask

    // Drives a request at the negedge, lets it be accepted, returns in cycle N+1.
    task automatic req(input string tag, input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = a;
        bus.i_req_data  = d;
        bus.i_req_size  = s;
        chk({tag, ".ready"}, 64'(bus.o_req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [63:0] idx, input logic [63:0] dat,
                        input logic [63:0] msk, input logic done);
        chk({tag, ".wen"}, 64'(bus.o_wen), 64'd1);
        chk({tag, ".widx"}, bus.o_widx, idx);
        chk({tag, ".wdata"}, bus.o_wdata, dat);
        chk({tag, ".wmask"}, bus.o_wmask, msk);
        chk({tag, ".done"}, 64'(bus.o_done), 64'(done));
        chk({tag, ".busy"}, 64'(bus.o_req_ready), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic back_to_idle(input string tag);
        chk({tag, ".ready"}, 64'(bus.o_req_ready), 64'd1);
        idle_chk(tag);
    endtask

    initial begin
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_data  = '0;
        bus.i_req_size  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 64'(bus.o_req_ready), 64'd0);
        idle_chk("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        back_to_idle("rel");

        req("dw", 64'h8000_0008, 64'h1122_3344_5566_7788, 2'b11);
        beat("dw.b0", 64'd1, 64'h1122_3344_5566_7788, '1, 1'b1);
        back_to_idle("dw.end");

        req("by", 64'h8000_0005, 64'hFFFF_FFFF_FFFF_FFAB, 2'b00);
        beat("by.b0", 64'd0, 64'h0000_AB00_0000_0000, 64'h0000_FF00_0000_0000, 1'b1);
        back_to_idle("by.end");

        req("hs", 64'h8000_0017, 64'h0000_0000_0000_BEEF, 2'b01);
        beat("hs.b0", 64'd2, 64'hEF00_0000_0000_0000, 64'hFF00_0000_0000_0000, 1'b0);
        beat("hs.b1", 64'd3, 64'h0000_0000_0000_00BE, 64'h0000_0000_0000_00FF, 1'b1);
        back_to_idle("hs.end");

        req("ds", 64'h8000_0003, 64'h0102_0304_0506_0708, 2'b11);
        beat("ds.b0", 64'd0, 64'h0405_0607_0800_0000, 64'hFFFF_FFFF_FF00_0000, 1'b0);
        beat("ds.b1", 64'd1, 64'h0000_0000_0001_0203, 64'h0000_0000_00FF_FFFF, 1'b1);
        back_to_idle("ds.end");

        req("ws", 64'h8000_0006, 64'h9999_9999_DDCC_BBAA, 2'b10);
        beat("ws.b0", 64'd0, 64'hBBAA_0000_0000_0000, 64'hFFFF_0000_0000_0000, 1'b0);
        beat("ws.b1", 64'd1, 64'h0000_0000_0000_DDCC, 64'h0000_0000_0000_FFFF, 1'b1);
        back_to_idle("ws.end");

        // Valid stays high: second request must wait out the first store's beat.
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 64'h8000_0004;
        bus.i_req_data  = 64'h1234_5678_AABB_CCDD;
        bus.i_req_size  = 2'b10;
        chk("b2b.rdy0", 64'(bus.o_req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.i_req_addr = 64'h8000_0000;
        bus.i_req_data = 64'hFFFF_FFFF_FFFF_FF77;
        bus.i_req_size = 2'b00;
        beat("b2b.w", 64'd0, 64'hAABB_CCDD_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1);
        back_to_idle("b2b.gap");
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
        beat("b2b.b", 64'd0, 64'h0000_0000_0000_0077, 64'h0000_0000_0000_00FF, 1'b1);
        back_to_idle("b2b.end");

        req("rm", 64'h8000_0003, 64'h0102_0304_0506_0708, 2'b11);
        chk("rm.b0wen", 64'(bus.o_wen), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rm.ready", 64'(bus.o_req_ready), 64'd0);
        idle_chk("rm.async");
        repeat (2) begin
            @(posedge clk);
            #1;
            idle_chk("rm.hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        back_to_idle("rm.rel");
        req("rm2", 64'h8000_0010, 64'hA5A5_5A5A_0F0F_F0F0, 2'b11);
        beat("rm2.b0", 64'd2, 64'hA5A5_5A5A_0F0F_F0F0, '1, 1'b1);
        back_to_idle("rm2.end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
